// File: rtl/adder_subtractor.sv
// Registered WIDTH-bit adder/subtractor built from a ripple chain of full-adder cells.
// The result and the carry/borrow flag appear one clock after the operands are sampled.
module adder_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] dout,
  output logic             carry_barrow
);

  logic [WIDTH-1:0] b_x;
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] dout_d, dout_q;
  logic             cb_d, cb_q;

  // Subtract is a + ~b + 1; a raw chain carry-out of 1 means "no borrow", so it is inverted when sel=1
  always_comb begin
    b_x    = b ^ {WIDTH{sel}};
    c      = '0;
    c[0]   = sel;
    dout_d = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      dout_d[i] = a[i] ^ b_x[i] ^ c[i];
      c[i+1]    = (a[i] & b_x[i]) | (c[i] & (a[i] ^ b_x[i]));
    end
    cb_d = c[WIDTH] ^ sel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= '0;
      cb_q   <= 1'b0;
    end else begin
      dout_q <= dout_d;
      cb_q   <= cb_d;
    end
  end

  assign dout         = dout_q;
  assign carry_barrow = cb_q;

endmodule

// File: tb/tb_adder_subtractor.sv
// Directed and exhaustive self-checking bench for adder_subtractor at WIDTH=4.
module tb_adder_subtractor;

  localparam int unsigned WIDTH = 4;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sel;
  logic [WIDTH-1:0] dout;
  logic             carry_barrow;

  int unsigned n_checks;
  int unsigned n_pass;

  adder_subtractor #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .a            (a),
    .b            (b),
    .sel          (sel),
    .dout         (dout),
    .carry_barrow (carry_barrow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Drive operands before an edge, then check the registered result just after it
  task automatic op(input logic [3:0] ta, input logic [3:0] tb, input logic ts,
                    input logic [3:0] exp_d, input logic exp_c, input string tag);
    @(negedge clk);
    a = ta; b = tb; sel = ts;
    @(posedge clk); #1;
    check({tag, ".dout"}, 32'(dout), 32'(exp_d));
    check({tag, ".cb"}, 32'(carry_barrow), 32'(exp_c));
  endtask

  initial begin
    logic [4:0] sum5;
    logic [3:0] exp_d;
    logic       exp_c;
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1; a = 4'hF; b = 4'hF; sel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.dout", 32'(dout), 32'h0);
    check("reset.cb", 32'(carry_barrow), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    op(4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0, "sub_eq");
    op(4'b1011, 4'b1100, 1'b1, 4'b1111, 1'b1, "sub_b1");
    op(4'b0101, 4'b1011, 1'b1, 4'b1010, 1'b1, "sub_b2");
    op(4'b1010, 4'b0101, 1'b0, 4'b1111, 1'b0, "add_nc");
    op(4'b1111, 4'b1000, 1'b0, 4'b0111, 1'b1, "add_c1");
    op(4'b1010, 4'b1101, 1'b0, 4'b0111, 1'b1, "add_c2");
    op(4'b0000, 4'b0001, 1'b1, 4'b1111, 1'b1, "sub_0m1");
    op(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, "add_zero");

    for (int k = 0; k < 4; k++) begin
      op(4'b0011, 4'b0101, 1'b0, 4'b1000, 1'b0, "b2b_add");
      op(4'b0011, 4'b0101, 1'b1, 4'b1110, 1'b1, "b2b_sub");
    end

    // Latency: after an edge, change inputs; outputs must hold until the next edge
    op(4'b0010, 4'b0011, 1'b0, 4'b0101, 1'b0, "lat_pre");
    a = 4'b1001; b = 4'b1000; sel = 1'b0;
    #3;
    check("lat_hold.dout", 32'(dout), 32'h5);
    check("lat_hold.cb", 32'(carry_barrow), 32'h0);
    @(posedge clk); #1;
    check("lat_new.dout", 32'(dout), 32'h1);
    check("lat_new.cb", 32'(carry_barrow), 32'h1);

    // Mid-stream reset discards the sampled operation
    @(negedge clk);
    a = 4'b1111; b = 4'b0001; sel = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid.dout", 32'(dout), 32'h0);
    check("rst_mid.cb", 32'(carry_barrow), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_rel.dout", 32'(dout), 32'h0);
    check("rst_rel.cb", 32'(carry_barrow), 32'h1);

    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 16; i++) begin
        for (int j = 0; j < 16; j++) begin
          if (s == 0) begin
            sum5  = 5'(i) + 5'(j);
            exp_d = sum5[3:0];
            exp_c = sum5[4];
          end else begin
            exp_d = 4'(i - j);
            exp_c = (i < j);
          end
          op(4'(i), 4'(j), s[0], exp_d, exp_c, "exh");
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
